// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
// Two-requester front end for a 4-phase bit-serial ALU. Requests are arbitrated
// round-robin, operands are latched at grant, and the operation is replayed to
// the ALU for one full slot cycle (phases 0..3) that always starts on slot 0.
// The result is captured one cycle after the run and handed back with a done
// pulse to the requester that owned the operation. Unsupported opcodes skip the
// ALU entirely and return an error completion one cycle after the grant.
module alu_op_scheduler #(
    parameter logic [2:0] IDLE_OP = 3'b111
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [2:0] op0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [2:0] op1,

    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,

    output logic [3:0] res_c,
    output logic       res_carr,
    output logic       res_sign,
    output logic       res_zero,
    output logic       res_err,

    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_c,
    input  logic       alu_carr,
    input  logic       alu_sign,
    input  logic       alu_zero,

    output logic       slot_sync,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SLOT = 3'd1,
        ST_RUN       = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_ERR       = 3'd4
    } state_t;

    // Last slot of the ALU phase cycle; WAIT_SLOT and RUN both leave on it.
    localparam logic [1:0] LAST_SLOT = 2'd3;

    state_t     state_q, state_d;
    logic [1:0] slot_q, slot_d;

    // prio_q = index of the requester that wins a tie (the one not served last)
    logic       prio_q, prio_d;
    logic       owner_q, owner_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [2:0] op_q, op_d;

    // One bit per requester: bit 0 = requester 0, bit 1 = requester 1
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;

    logic [3:0] res_c_q, res_c_d;
    logic       res_carr_q, res_carr_d;
    logic       res_sign_q, res_sign_d;
    logic       res_zero_q, res_zero_d;
    logic       res_err_q, res_err_d;

    // Arbitration results for the current cycle
    logic [1:0] req_v;
    logic       any_req;
    logic       win;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic [2:0] sel_op;
    logic       sel_valid;

    // Only AND/XOR/ADD style codes are understood by the ALU behind us.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b011);
    endfunction

    // Free-running phase counter, wraps 3 -> 0
    always_comb begin
        slot_d = slot_q + 2'd1;
    end

    // Round-robin pick between the two requesters and operand selection
    always_comb begin
        req_v   = {req1, req0};
        any_req = |req_v;
        if (req_v == 2'b11) begin
            win = prio_q;
        end else begin
            win = req_v[1];
        end
        sel_a     = win ? a1  : a0;
        sel_b     = win ? b1  : b0;
        sel_op    = win ? op1 : op0;
        sel_valid = op_is_valid(sel_op);
    end

    // Next-state logic of the operation sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = sel_valid ? ST_WAIT_SLOT : ST_ERR;
                end
            end
            ST_WAIT_SLOT: begin
                // Leaving on slot 3 makes the first RUN cycle land on slot 0.
                if (slot_q == LAST_SLOT) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // RUN began on slot 0, so slot 3 is its fourth and last cycle.
                if (slot_q == LAST_SLOT) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand latch, ownership, round-robin pointer, pulses and result capture
    always_comb begin
        prio_d     = prio_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        res_c_d    = res_c_q;
        res_carr_d = res_carr_q;
        res_sign_d = res_sign_q;
        res_zero_d = res_zero_q;
        res_err_d  = res_err_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d    = win;
                    a_d        = sel_a;
                    b_d        = sel_b;
                    op_d       = sel_op;
                    prio_d     = ~win;
                    gnt_d[win] = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // The ALU holds its final phase result through this cycle.
                res_c_d        = alu_c;
                res_carr_d     = alu_carr;
                res_sign_d     = alu_sign;
                res_zero_d     = alu_zero;
                res_err_d      = 1'b0;
                done_d[owner_q] = 1'b1;
            end
            ST_ERR: begin
                // Previous result stays visible; only the error flag changes.
                res_err_d       = 1'b1;
                done_d[owner_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Output decode: ALU is only driven while RUN is active
    always_comb begin
        if (state_q == ST_RUN) begin
            alu_a  = a_q;
            alu_b  = b_q;
            alu_op = op_q;
        end else begin
            alu_a  = 4'd0;
            alu_b  = 4'd0;
            alu_op = IDLE_OP;
        end
        gnt0      = gnt_q[0];
        gnt1      = gnt_q[1];
        done0     = done_q[0];
        done1     = done_q[1];
        res_c     = res_c_q;
        res_carr  = res_carr_q;
        res_sign  = res_sign_q;
        res_zero  = res_zero_q;
        res_err   = res_err_q;
        slot_sync = (slot_q == 2'd0);
        // The gnt cycle is already a non-IDLE state; the done cycle is IDLE,
        // so the done pulse is folded in to keep busy high through it.
        busy      = (state_q != ST_IDLE) || (|done_q);
    end

    // State and slot counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Control and operand registers; reset drops any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            op_q    <= IDLE_OP;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
        end else begin
            prio_q  <= prio_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    // Result registers; reset value reads as a zero result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_c_q    <= 4'd0;
            res_carr_q <= 1'b0;
            res_sign_q <= 1'b0;
            res_zero_q <= 1'b1;
            res_err_q  <= 1'b0;
        end else begin
            res_c_q    <= res_c_d;
            res_carr_q <= res_carr_d;
            res_sign_q <= res_sign_d;
            res_zero_q <= res_zero_d;
            res_err_q  <= res_err_d;
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Testbench for alu_op_scheduler: directed steps, a per-requester scoreboard
// of expected completions and a small ALU stand-in that answers the runs.
module tb_alu_op_scheduler;

    localparam logic [2:0] IDLE_OP = 3'b111;

    typedef struct packed {
        logic [3:0] c;
        logic       carr;
        logic       sign;
        logic       zero;
        logic       err;
    } res_t;

    localparam res_t RES_RST  = '{c: 4'h0, carr: 1'b0, sign: 1'b0, zero: 1'b1, err: 1'b0};
    localparam res_t ALU_JUNK = '{c: 4'h5, carr: 1'b1, sign: 1'b1, zero: 1'b1, err: 1'b0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic       gnt0, gnt1, done0, done1;
    logic [3:0] res_c;
    logic       res_carr, res_sign, res_zero, res_err;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_c;
    logic       alu_carr, alu_sign, alu_zero;
    logic       slot_sync, busy;

    always #5 clk = ~clk;

    alu_op_scheduler #(.IDLE_OP(IDLE_OP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res_c(res_c), .res_carr(res_carr), .res_sign(res_sign),
        .res_zero(res_zero), .res_err(res_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_carr(alu_carr), .alu_sign(alu_sign), .alu_zero(alu_zero),
        .slot_sync(slot_sync), .busy(busy)
    );

    // Reference ALU: 000 AND, 001 XOR, 011 ADD
    function automatic res_t alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        res_t       r;
        logic [4:0] s;
        r = '0;
        s = 5'd0;
        case (op)
            3'b000: r.c = a & b;
            3'b001: r.c = a ^ b;
            3'b011: begin
                s      = {1'b0, a} + {1'b0, b};
                r.c    = s[3:0];
                r.carr = s[4];
            end
            default: r.c = 4'h5;
        endcase
        r.sign = r.c[3];
        r.zero = (r.c == 4'h0);
        return r;
    endfunction

    function automatic logic valid_op(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b011);
    endfunction

    // ALU stand-in: result valid for exactly one cycle after a run, junk otherwise
    res_t stub_q    = ALU_JUNK;
    logic stub_hold = 1'b0;
    always @(posedge clk) begin
        if (alu_op != IDLE_OP) begin
            stub_q    <= alu_f(alu_a, alu_b, alu_op);
            stub_hold <= 1'b1;
        end else if (stub_hold) begin
            stub_hold <= 1'b0;
        end else begin
            stub_q <= ALU_JUNK;
        end
    end
    assign alu_c    = stub_q.c;
    assign alu_carr = stub_q.carr;
    assign alu_sign = stub_q.sign;
    assign alu_zero = stub_q.zero;

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   slot_m  = 0;
    res_t q0[$];
    res_t q1[$];
    res_t exp_res = RES_RST;
    int   exp_done[2];
    int   gnt_cyc[2];
    int   done_cyc[2];
    int   done_cnt[2];
    logic gnt_flag[2];
    logic [3:0] drv_a[2];
    logic [3:0] drv_b[2];
    logic [2:0] drv_op[2];
    logic [3:0] cur_a = 4'h0;
    logic [3:0] cur_b = 4'h0;
    logic [2:0] cur_op = IDLE_OP;
    int   run_len   = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Per-cycle observation: scoreboard pops, hold checks, ALU drive checks
    task automatic monitor(input logic rst_edge);
        logic [1:0] g;
        logic [1:0] d;
        res_t       e;
        int         qs;
        g = {gnt1, gnt0};
        d = {done1, done0};
        if (rst_edge) begin
            q0.delete();
            q1.delete();
            exp_res = RES_RST;
            run_len = 0;
        end
        chk("slot_sync", 16'(slot_sync), 16'(slot_m == 0));
        chk("gnt_exclusive", 16'(g == 2'b11), 16'd0);
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                gnt_flag[i] = 1'b1;
                gnt_cyc[i]  = cyc;
                chk("gnt_while_busy", 16'(!prev_busy || prev_done), 16'd1);
                chk("busy_at_gnt", 16'(busy), 16'd1);
                cur_a  = drv_a[i];
                cur_b  = drv_b[i];
                cur_op = drv_op[i];
                exp_done[i] = valid_op(drv_op[i]) ? cyc + 9 - slot_m : cyc + 1;
            end
            if (d[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
                chk("busy_at_done", 16'(busy), 16'd1);
                chk("done_cycle", 16'(cyc), 16'(exp_done[i]));
                qs = (i == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    chk("spurious_done", 16'd1, 16'd0);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    if (e.err) exp_res.err = 1'b1;
                    else       exp_res = e;
                end
            end
        end
        chk("res_value", 16'({res_c, res_carr, res_sign, res_zero, res_err}), 16'(exp_res));
        if (alu_op !== IDLE_OP) begin
            if (run_len == 0) begin
                chk("run_start_slot", 16'(slot_m), 16'd0);
                chk("run_op_valid", 16'(valid_op(cur_op)), 16'd1);
            end
            chk("run_operands", 16'({alu_a, alu_b, alu_op}), 16'({cur_a, cur_b, cur_op}));
            run_len++;
        end else begin
            chk("alu_idle_zero", 16'({alu_a, alu_b}), 16'd0);
            if (run_len != 0) chk("run_length", 16'(run_len), 16'd4);
            run_len = 0;
        end
        prev_busy = busy;
        prev_done = |d;
    endtask

    task automatic step();
        logic r;
        r = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        slot_m = r ? (slot_m + 1) % 4 : 0;
        monitor(!r);
    endtask

    task automatic drive(input int i, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (i == 0) begin req0 = v; a0 = a; b0 = b; op0 = op; end
        else        begin req1 = v; a1 = a; b1 = b; op1 = op; end
    endtask

    task automatic drop(input int i);
        if (i == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic push(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        res_t e;
        e     = alu_f(a, b, op);
        e.err = !valid_op(op);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        drv_a[i]  = a;
        drv_b[i]  = b;
        drv_op[i] = op;
    endtask

    task automatic wait_gnt(input int i);
        int n = 0;
        while (!gnt_flag[i] && n < 40) begin
            step();
            n++;
        end
        chk($sformatf("gnt%0d_arrived", i), 16'(gnt_flag[i]), 16'd1);
    endtask

    task automatic wait_done(input int i, input int target);
        int n = 0;
        while (done_cnt[i] < target && n < 40) begin
            step();
            n++;
        end
        chk($sformatf("done%0d_arrived", i), 16'(done_cnt[i] >= target), 16'd1);
    endtask

    task automatic issue(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int t;
        t = done_cnt[i] + 1;
        push(i, a, b, op);
        gnt_flag[i] = 1'b0;
        drive(i, 1'b1, a, b, op);
        wait_gnt(i);
        drop(i);
        wait_done(i, t);
    endtask

    task automatic pair(input int exp_first, input logic [3:0] a_0, input logic [3:0] b_0,
                        input logic [3:0] a_1, input logic [3:0] b_1);
        int t0, t1, n, first;
        t0 = done_cnt[0] + 1;
        t1 = done_cnt[1] + 1;
        push(0, a_0, b_0, 3'b011);
        push(1, a_1, b_1, 3'b011);
        gnt_flag[0] = 1'b0;
        gnt_flag[1] = 1'b0;
        drive(0, 1'b1, a_0, b_0, 3'b011);
        drive(1, 1'b1, a_1, b_1, 3'b011);
        n = 0;
        while (!gnt_flag[0] && !gnt_flag[1] && n < 40) begin
            step();
            n++;
        end
        first = gnt_flag[1] ? 1 : 0;
        chk("rr_first_winner", 16'(first), 16'(exp_first));
        drop(first);
        wait_gnt(1 - first);
        drop(1 - first);
        wait_done(0, t0);
        wait_done(1, t1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pulses"}, 16'({gnt0, gnt1, done0, done1, busy}), 16'd0);
        chk({tag, "_alu"}, 16'({alu_a, alu_b, alu_op}), 16'({4'h0, 4'h0, IDLE_OP}));
        chk({tag, "_res"}, 16'({res_c, res_carr, res_sign, res_zero, res_err}), 16'(RES_RST));
        chk({tag, "_slot"}, 16'(slot_sync), 16'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            exp_done[i] = 0;
            gnt_cyc[i]  = 0;
            done_cyc[i] = 0;
            done_cnt[i] = 0;
            gnt_flag[i] = 1'b0;
            drv_a[i]    = 4'h0;
            drv_b[i]    = 4'h0;
            drv_op[i]   = IDLE_OP;
        end
        rst_n = 1'b0;
        drive(0, 1'b0, 4'h0, 4'h0, 3'b000);
        drive(1, 1'b0, 4'h0, 4'h0, 3'b000);
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // XOR example: 1010 ^ 0110 = 1100, busy drops after done
        issue(0, 4'b1010, 4'b0110, 3'b001);
        chk("xor_res_c", 16'(res_c), 16'(4'b1100));
        step();
        chk("busy_after_done", 16'(busy), 16'd0);

        // AND giving zero: res 0000 with zero flag only
        issue(0, 4'b1010, 4'b0101, 3'b000);
        chk("and_zero_flags", 16'({res_c, res_carr, res_sign, res_zero, res_err}), 16'(8'b0000_0010));

        // Invalid opcode: error completion one cycle after grant, res_c kept
        issue(1, 4'b1111, 4'b1111, 3'b111);
        chk("err_latency", 16'(done_cyc[1] - gnt_cyc[1]), 16'd1);
        chk("err_res", 16'({res_c, res_err}), 16'({4'b0000, 1'b1}));

        // Grant landing on each slot: cycles between gnt and done are 8 - slot
        for (int x = 0; x < 4; x++) begin
            n = 0;
            while (slot_m != (x + 3) % 4 && n < 8) begin
                step();
                n++;
            end
            issue(0, 4'(x + 9), 4'b0111, 3'b011);
            chk($sformatf("latency_slot%0d", x), 16'(done_cyc[0] - gnt_cyc[0] - 1), 16'(8 - x));
        end

        // Round robin after a fresh reset
        rst_n = 1'b0;
        step();
        check_reset_outputs("reset2");
        rst_n = 1'b1;
        pair(0, 4'b1111, 4'b0001, 4'b0011, 4'b0100);
        pair(0, 4'b0110, 4'b0110, 4'b1000, 4'b1000);
        issue(0, 4'b0001, 4'b0001, 3'b011);
        pair(1, 4'b0010, 4'b0011, 4'b1001, 4'b0111);

        // Reset during the second RUN cycle aborts without a done
        push(0, 4'b0101, 4'b0101, 3'b011);
        gnt_flag[0] = 1'b0;
        drive(0, 1'b1, 4'b0101, 4'b0101, 3'b011);
        wait_gnt(0);
        drop(0);
        n = 0;
        while (run_len != 2 && n < 20) begin
            step();
            n++;
        end
        chk("reached_run2", 16'(run_len), 16'd2);
        rst_n = 1'b0;
        step();
        check_reset_outputs("abort");
        rst_n = 1'b1;
        n = done_cnt[0];
        repeat (12) step();
        chk("no_done_after_abort", 16'(done_cnt[0] - n), 16'd0);
        issue(0, 4'b0011, 4'b1100, 3'b001);

        // Request held past its grant counts as a second request
        push(1, 4'b1100, 4'b0110, 3'b011);
        push(1, 4'b1100, 4'b0110, 3'b011);
        n = done_cnt[1] + 2;
        gnt_flag[1] = 1'b0;
        drive(1, 1'b1, 4'b1100, 4'b0110, 3'b011);
        wait_gnt(1);
        gnt_flag[1] = 1'b0;
        wait_gnt(1);
        drop(1);
        wait_done(1, n);
        chk("held_req_res", 16'({res_c, res_carr}), 16'({4'b0010, 1'b1}));

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
